// File: rtl/mmu_pkg.sv
// Shared types for the Sv32 translation unit: access types, privilege codes,
// PTE/TLB layouts, walker states and the leaf permission check.
package mmu_pkg;

   typedef enum logic [1:0] {
      ACC_FETCH = 2'b00,
      ACC_LOAD  = 2'b01,
      ACC_STORE = 2'b10
   } acc_t;

   localparam logic [1:0] PRIV_U = 2'b00;
   localparam logic [1:0] PRIV_S = 2'b01;
   localparam logic [1:0] PRIV_M = 2'b11;

   typedef struct packed {
      logic [21:0] ppn;
      logic [1:0]  rsw;
      logic        d;
      logic        a;
      logic        g;
      logic        u;
      logic        x;
      logic        w;
      logic        r;
      logic        v;
   } pte_t;

   typedef struct packed {
      logic        valid;
      logic        mega;
      logic [19:0] vpn;
      logic [21:0] ppn;
      logic        r;
      logic        w;
      logic        x;
      logic        u;
      logic        d;
   } tlb_entry_t;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_L1_REQ  = 3'd1,
      ST_L1_WAIT = 3'd2,
      ST_L0_REQ  = 3'd3,
      ST_L0_WAIT = 3'd4,
      ST_RESP    = 3'd5
   } walk_state_t;

   // R/W/X by access type, then the U-bit rules for U and S privilege.
   function automatic logic perm_ok(input logic i_r, input logic i_w,
                                    input logic i_x, input logic i_u,
                                    input acc_t i_acc, input logic [1:0] i_priv,
                                    input logic i_sum);
      logic ok;
      case (i_acc)
         ACC_FETCH: ok = i_x;
         ACC_STORE: ok = i_w;
         default:   ok = i_r;
      endcase
      if (i_priv == PRIV_U && !i_u) ok = 1'b0;
      if (i_priv == PRIV_S && i_u && (i_acc == ACC_FETCH || !i_sum)) ok = 1'b0;
      return ok;
   endfunction

endpackage

// File: rtl/mmu_tlb_cam.sv
// Fully-associative TLB array: parallel match with lowest-index priority,
// single install port at a round-robin pointer, and a global flush.
import mmu_pkg::*;

module mmu_tlb_cam #(
   parameter int ENTRIES = 16
)(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       i_flush,
   input  logic [19:0] i_vpn,
   output logic       o_hit,
   output tlb_entry_t o_entry,
   input  logic       i_install,
   input  tlb_entry_t i_entry
);

   localparam int IDX_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

   tlb_entry_t       r_entries [ENTRIES];
   logic [IDX_W-1:0] r_ptr;
   logic [IDX_W-1:0] w_ptr_next;

   // Scan downwards so the lowest matching index is the one left standing.
   always_comb begin
      o_hit   = 1'b0;
      o_entry = '0;
      for (int i = ENTRIES - 1; i >= 0; i--) begin
         if (r_entries[i].valid &&
             (r_entries[i].vpn[19:10] == i_vpn[19:10]) &&
             (r_entries[i].mega || (r_entries[i].vpn[9:0] == i_vpn[9:0]))) begin
            o_hit   = 1'b1;
            o_entry = r_entries[i];
         end
      end
   end

   assign w_ptr_next = (r_ptr == IDX_W'(ENTRIES - 1)) ? '0 : r_ptr + 1'b1;

   // Flush has priority: an install in the same cycle is dropped.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < ENTRIES; i++) r_entries[i] <= '0;
         r_ptr <= '0;
      end else if (i_flush) begin
         for (int i = 0; i < ENTRIES; i++) r_entries[i].valid <= 1'b0;
      end else if (i_install) begin
         r_entries[r_ptr] <= i_entry;
         r_ptr            <= w_ptr_next;
      end
   end

endmodule

// File: rtl/mmu_sv32_tlb.sv
// Sv32 translation unit: TLB lookup, bare/M-mode bypass and two-level walker.
// Optional MMU_AD_CHECK_EN makes A=0 leaves and stores to D=0 pages fault.
import mmu_pkg::*;

module mmu_sv32_tlb #(
   parameter int TLB_ENTRIES = 16,
   parameter int VADDR_WIDTH = 32,
   parameter int PADDR_WIDTH = 34
)(
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   req_valid,
   output logic                   req_ready,
   input  logic [VADDR_WIDTH-1:0] req_vaddr,
   input  logic [1:0]             req_type,
   input  logic [1:0]             priv,
   input  logic [31:0]            satp,
   input  logic                   sum,
   input  logic                   sfence_valid,
   output logic                   resp_valid,
   output logic [PADDR_WIDTH-1:0] resp_paddr,
   output logic                   resp_fault,
   output logic                   resp_hit,
   output logic                   ptw_req_valid,
   input  logic                   ptw_req_ready,
   output logic [PADDR_WIDTH-1:0] ptw_req_addr,
   input  logic                   ptw_resp_valid,
   input  logic [31:0]            ptw_resp_data
);

   walk_state_t r_state, w_next_state;

   logic [VADDR_WIDTH-1:0] r_vaddr;
   acc_t                   r_acc;
   logic [1:0]             r_priv;
   logic                   r_sum;
   logic [21:0]            r_root;
   logic [21:0]            r_l1_ppn;
   logic [PADDR_WIDTH-1:0] r_resp_paddr;
   logic                   r_resp_fault;
   logic                   r_resp_hit;
   logic                   r_install;
   tlb_entry_t             r_inst_entry;
   logic                   r_sfence_seen;

   acc_t                   w_acc_in;
   logic                   w_accept;
   logic                   w_bypass;
   logic                   w_cam_hit;
   tlb_entry_t             w_hit_entry;
   logic                   w_hit_ok;
   pte_t                   w_pte;
   logic                   w_pte_bad;
   logic                   w_pte_leaf;
   logic                   w_walk_ok;
   logic                   w_load_req;
   logic                   w_load_l1;
   logic                   w_load_resp;
   logic [PADDR_WIDTH-1:0] w_resp_paddr;
   logic                   w_resp_fault;
   logic                   w_resp_hit;
   logic                   w_install;
   tlb_entry_t             w_inst_entry;
   logic                   w_cam_install;
   logic                   w_unused;

   assign req_ready  = (r_state == ST_IDLE) && !sfence_valid;
   assign w_accept   = req_valid && req_ready;
   assign w_acc_in   = (req_type == 2'b11) ? ACC_LOAD : acc_t'(req_type);
   assign w_bypass   = !satp[31] || (priv == PRIV_M);
   assign w_pte      = pte_t'(ptw_resp_data);
   assign w_pte_bad  = !w_pte.v || (!w_pte.r && w_pte.w);
   assign w_pte_leaf = w_pte.r || w_pte.x;

   assign resp_valid = (r_state == ST_RESP);
   assign resp_paddr = r_resp_paddr;
   assign resp_fault = r_resp_fault;
   assign resp_hit   = r_resp_hit;

   // A flush seen at any point of the walk, or in the response cycle, blocks the install.
   assign w_cam_install = (r_state == ST_RESP) && r_install && !r_sfence_seen && !sfence_valid;

   assign w_unused = ^{satp[30:22], w_pte.rsw, w_pte.g, w_pte.a, w_pte.d,
                       w_hit_entry.valid, w_hit_entry.d};

   mmu_tlb_cam #(.ENTRIES(TLB_ENTRIES)) u_cam (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_flush   (sfence_valid),
      .i_vpn     (req_vaddr[31:12]),
      .o_hit     (w_cam_hit),
      .o_entry   (w_hit_entry),
      .i_install (w_cam_install),
      .i_entry   (r_inst_entry)
   );

   always_comb begin
      w_hit_ok = perm_ok(w_hit_entry.r, w_hit_entry.w, w_hit_entry.x, w_hit_entry.u,
                         w_acc_in, priv, sum);
      w_walk_ok = perm_ok(w_pte.r, w_pte.w, w_pte.x, w_pte.u, r_acc, r_priv, r_sum);
`ifdef MMU_AD_CHECK_EN
      if (w_acc_in == ACC_STORE && !w_hit_entry.d) w_hit_ok = 1'b0;
      if (!w_pte.a || (r_acc == ACC_STORE && !w_pte.d)) w_walk_ok = 1'b0;
`endif
   end

   always_comb begin
      w_next_state       = r_state;
      ptw_req_valid      = 1'b0;
      ptw_req_addr       = '0;
      w_load_req         = 1'b0;
      w_load_l1          = 1'b0;
      w_load_resp        = 1'b0;
      w_resp_paddr       = '0;
      w_resp_fault       = 1'b0;
      w_resp_hit         = 1'b0;
      w_install          = 1'b0;
      w_inst_entry       = '0;
      w_inst_entry.valid = 1'b1;
      w_inst_entry.vpn   = r_vaddr[31:12];
      w_inst_entry.ppn   = w_pte.ppn;
      w_inst_entry.r     = w_pte.r;
      w_inst_entry.w     = w_pte.w;
      w_inst_entry.x     = w_pte.x;
      w_inst_entry.u     = w_pte.u;
`ifdef MMU_AD_CHECK_EN
      w_inst_entry.d     = w_pte.d;
`endif
      case (r_state)
         ST_IDLE: begin
            if (w_accept) begin
               w_load_req = 1'b1;
               if (w_bypass) begin
                  w_load_resp  = 1'b1;
                  w_resp_hit   = 1'b1;
                  w_resp_paddr = PADDR_WIDTH'(req_vaddr);
                  w_next_state = ST_RESP;
               end else if (w_cam_hit) begin
                  w_load_resp  = 1'b1;
                  w_resp_hit   = 1'b1;
                  w_resp_fault = !w_hit_ok;
                  if (w_hit_ok)
                     w_resp_paddr = w_hit_entry.mega ?
                        PADDR_WIDTH'({w_hit_entry.ppn[21:10], req_vaddr[21:0]}) :
                        PADDR_WIDTH'({w_hit_entry.ppn, req_vaddr[11:0]});
                  w_next_state = ST_RESP;
               end else begin
                  w_next_state = ST_L1_REQ;
               end
            end
         end
         ST_L1_REQ: begin
            ptw_req_valid = 1'b1;
            ptw_req_addr  = PADDR_WIDTH'({r_root, r_vaddr[31:22], 2'b00});
            if (ptw_req_ready) w_next_state = ST_L1_WAIT;
         end
         ST_L1_WAIT: begin
            if (ptw_resp_valid) begin
               if (w_pte_bad || w_pte_leaf) begin
                  w_load_resp  = 1'b1;
                  w_next_state = ST_RESP;
                  if (w_pte_bad || (w_pte.ppn[9:0] != 10'd0) || !w_walk_ok) begin
                     w_resp_fault = 1'b1;
                  end else begin
                     w_resp_paddr      = PADDR_WIDTH'({w_pte.ppn[21:10], r_vaddr[21:0]});
                     w_install         = 1'b1;
                     w_inst_entry.mega = 1'b1;
                  end
               end else begin
                  w_load_l1    = 1'b1;
                  w_next_state = ST_L0_REQ;
               end
            end
         end
         ST_L0_REQ: begin
            ptw_req_valid = 1'b1;
            ptw_req_addr  = PADDR_WIDTH'({r_l1_ppn, r_vaddr[21:12], 2'b00});
            if (ptw_req_ready) w_next_state = ST_L0_WAIT;
         end
         ST_L0_WAIT: begin
            if (ptw_resp_valid) begin
               w_load_resp  = 1'b1;
               w_next_state = ST_RESP;
               if (w_pte_bad || !w_pte_leaf || !w_walk_ok) begin
                  w_resp_fault = 1'b1;
               end else begin
                  w_resp_paddr = PADDR_WIDTH'({w_pte.ppn, r_vaddr[11:0]});
                  w_install    = 1'b1;
               end
            end
         end
         ST_RESP:  w_next_state = ST_IDLE;
         default:  w_next_state = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= ST_IDLE;
      else        r_state <= w_next_state;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_vaddr       <= '0;
         r_acc         <= ACC_FETCH;
         r_priv        <= '0;
         r_sum         <= 1'b0;
         r_root        <= '0;
         r_l1_ppn      <= '0;
         r_resp_paddr  <= '0;
         r_resp_fault  <= 1'b0;
         r_resp_hit    <= 1'b0;
         r_install     <= 1'b0;
         r_inst_entry  <= '0;
         r_sfence_seen <= 1'b0;
      end else begin
         if (w_load_req) begin
            r_vaddr <= req_vaddr;
            r_acc   <= w_acc_in;
            r_priv  <= priv;
            r_sum   <= sum;
            r_root  <= satp[21:0];
         end
         if (w_load_l1) r_l1_ppn <= w_pte.ppn;
         if (w_load_resp) begin
            r_resp_paddr <= w_resp_paddr;
            r_resp_fault <= w_resp_fault;
            r_resp_hit   <= w_resp_hit;
            r_install    <= w_install;
            r_inst_entry <= w_inst_entry;
         end
         if (w_accept)                                   r_sfence_seen <= 1'b0;
         else if (sfence_valid && (r_state != ST_IDLE)) r_sfence_seen <= 1'b1;
      end
   end

endmodule

// File: tb/tb_mmu_sv32_tlb.sv
// Directed bench for mmu_sv32_tlb: expected responses and PTE addresses are
// queued at issue time and checked by independent monitors.
module tb_mmu_sv32_tlb;

   localparam logic [1:0] T_FETCH = 2'b00, T_LOAD = 2'b01, T_STORE = 2'b10;
   localparam logic [1:0] P_U = 2'b00, P_S = 2'b01, P_M = 2'b11;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid;
   logic        req_ready;
   logic [31:0] req_vaddr;
   logic [1:0]  req_type;
   logic [1:0]  priv;
   logic [31:0] satp;
   logic        sum;
   logic        sfence_valid;
   logic        resp_valid;
   logic [33:0] resp_paddr;
   logic        resp_fault;
   logic        resp_hit;
   logic        ptw_req_valid;
   logic        ptw_req_ready;
   logic [33:0] ptw_req_addr;
   logic        ptw_resp_valid = 1'b0;
   logic [31:0] ptw_resp_data  = 32'h0;

   logic [35:0] exp_q[$];
   int          exp_lat_q[$];
   logic [33:0] exp_ptw_q[$];
   logic [31:0] pte_mem [logic [33:0]];

   int    n_tests    = 0;
   int    n_fail     = 0;
   int    cyc        = 0;
   int    t_acc      = 0;
   int    resp_delay = 0;
   string cur_name   = "reset";

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   mmu_sv32_tlb #(.TLB_ENTRIES(16), .VADDR_WIDTH(32), .PADDR_WIDTH(34)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_vaddr(req_vaddr),
      .req_type(req_type), .priv(priv), .satp(satp), .sum(sum),
      .sfence_valid(sfence_valid),
      .resp_valid(resp_valid), .resp_paddr(resp_paddr),
      .resp_fault(resp_fault), .resp_hit(resp_hit),
      .ptw_req_valid(ptw_req_valid), .ptw_req_ready(ptw_req_ready),
      .ptw_req_addr(ptw_req_addr),
      .ptw_resp_valid(ptw_resp_valid), .ptw_resp_data(ptw_resp_data)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Response monitor: every resp_valid pulse must match the head of exp_q.
   initial begin
      logic [35:0] e;
      int          l;
      forever begin
         @(negedge clk);
         if (rst_n && resp_valid) begin
            if (exp_q.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL %s/unexpected_resp: got paddr 0x%0h expected no response", cur_name, resp_paddr);
            end else begin
               e = exp_q.pop_front();
               l = exp_lat_q.pop_front();
               chk({cur_name, "/resp{paddr,fault,hit}"}, {28'h0, resp_paddr, resp_fault, resp_hit}, {28'h0, e});
               if (l != 0) chk({cur_name, "/latency"}, 64'(cyc - t_acc), 64'(l));
            end
         end
      end
   end

   // PTE-read monitor: every accepted walker read must match the head of exp_ptw_q.
   initial begin
      forever begin
         @(negedge clk);
         if (rst_n && ptw_req_valid && ptw_req_ready) begin
            if (exp_ptw_q.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL %s/unexpected_ptw: got addr 0x%0h expected no PTE read", cur_name, ptw_req_addr);
            end else begin
               chk({cur_name, "/ptw_addr"}, 64'(ptw_req_addr), 64'(exp_ptw_q.pop_front()));
            end
         end
      end
   end

   // Memory responder: returns the PTE resp_delay cycles after the read is accepted.
   initial begin
      int          cnt = 0;
      logic [31:0] pend = 32'h0;
      forever begin
         @(negedge clk);
         ptw_resp_valid = 1'b0;
         if (cnt > 0) begin
            cnt--;
            if (cnt == 0) begin
               ptw_resp_valid = 1'b1;
               ptw_resp_data  = pend;
            end
         end
         if (rst_n && ptw_req_valid && ptw_req_ready) begin
            pend = pte_mem.exists(ptw_req_addr) ? pte_mem[ptw_req_addr] : 32'h0;
            cnt  = resp_delay + 1;
         end
      end
   end

   task automatic send(input logic [31:0] va, input logic [1:0] ty, input logic [1:0] pv, input logic sm);
      int n = 0;
      while (!req_ready && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      if (!req_ready) begin
         n_tests++;
         n_fail++;
         $display("FAIL %s/req_ready: got 0 expected 1", cur_name);
      end
      req_vaddr = va;
      req_type  = ty;
      priv      = pv;
      sum       = sm;
      req_valid = 1'b1;
      t_acc     = cyc;
      @(posedge clk); #1;
      req_valid = 1'b0;
   endtask

   task automatic wait_done();
      int n = 0;
      while (exp_q.size() != 0 && n < 300) begin
         @(posedge clk);
         n++;
      end
      #1;
      if (exp_q.size() != 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL %s/timeout: got %0d pending responses expected 0", cur_name, exp_q.size());
         exp_q.delete();
         exp_lat_q.delete();
      end
   endtask

   task automatic expect_resp(input string name, input logic [33:0] pa, input logic f, input logic h, input int lat);
      cur_name = name;
      exp_q.push_back({pa, f, h});
      exp_lat_q.push_back(lat);
   endtask

   task automatic txn(input string name, input logic [31:0] va, input logic [1:0] ty, input logic [1:0] pv,
                      input logic sm, input logic [33:0] pa, input logic f, input logic h, input int lat);
      expect_resp(name, pa, f, h, lat);
      send(va, ty, pv, sm);
      wait_done();
   endtask

   task automatic pulse_sfence();
      sfence_valid = 1'b1;
      @(posedge clk); #1;
      sfence_valid = 1'b0;
   endtask

   initial begin
      logic [31:0] va;
      logic [33:0] l1;
      rst_n = 1'b0; req_valid = 1'b0; req_vaddr = '0; req_type = '0; priv = '0;
      satp = '0; sum = 1'b0; sfence_valid = 1'b0; ptw_req_ready = 1'b1;

      pte_mem[34'h010_0004] = 32'h0000_2001;
      pte_mem[34'h000_8004] = 32'h0012_340F;
      pte_mem[34'h010_0008] = 32'h2000_00CF;
      pte_mem[34'h010_000C] = 32'h2000_04CF;
      pte_mem[34'h010_0010] = 32'h0000_2401;
      pte_mem[34'h000_9000] = 32'h0001_54C7;
      pte_mem[34'h010_0014] = 32'h0000_2401;
      pte_mem[34'h000_9004] = 32'h0001_98D3;

      repeat (3) @(posedge clk);
      #1;
      chk("reset/outputs", {58'h0, req_ready, resp_valid, ptw_req_valid, resp_fault, resp_hit, 1'b0},
          {58'h0, 1'b1, 5'b0});
      chk("reset/paddrs", {resp_paddr, 30'h0}, 64'h0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      satp = 32'h0;
      txn("bypass_satp0", 32'h1234_5678, T_LOAD, P_S, 1'b0, 34'h0_1234_5678, 1'b0, 1'b1, 1);
      satp = 32'h8000_0100;
      txn("bypass_mmode", 32'hDEAD_BEE0, T_STORE, P_M, 1'b0, 34'h0_DEAD_BEE0, 1'b0, 1'b1, 1);

      exp_ptw_q.push_back(34'h010_0004);
      exp_ptw_q.push_back(34'h000_8004);
      txn("walk_4k", 32'h0040_1004, T_LOAD, P_S, 1'b0, 34'h0_0048_D004, 1'b0, 1'b0, 0);
      txn("hit_4k", 32'h0040_1ABC, T_LOAD, P_S, 1'b0, 34'h0_0048_DABC, 1'b0, 1'b1, 1);

      exp_ptw_q.push_back(34'h010_0008);
      txn("walk_mega", 32'h0081_2345, T_LOAD, P_S, 1'b0, 34'h0_8001_2345, 1'b0, 1'b0, 0);
      txn("hit_mega", 32'h00BF_FFFC, T_FETCH, P_S, 1'b0, 34'h0_803F_FFFC, 1'b0, 1'b1, 1);

      exp_ptw_q.push_back(34'h010_000C);
      txn("mega_misaligned", 32'h00C0_0000, T_LOAD, P_S, 1'b0, 34'h0, 1'b1, 1'b0, 0);
      exp_ptw_q.push_back(34'h010_000C);
      txn("mega_misaligned_again", 32'h00C0_0010, T_LOAD, P_S, 1'b0, 34'h0, 1'b1, 1'b0, 0);

      exp_ptw_q.push_back(34'h010_0010);
      exp_ptw_q.push_back(34'h000_9000);
      txn("u_store_supervisor_page", 32'h0100_0010, T_STORE, P_U, 1'b0, 34'h0, 1'b1, 1'b0, 0);
      exp_ptw_q.push_back(34'h010_0010);
      exp_ptw_q.push_back(34'h000_9000);
      txn("s_store_walk", 32'h0100_0010, T_STORE, P_S, 1'b0, 34'h0_0005_5010, 1'b0, 1'b0, 0);
      txn("u_load_hit_supervisor_page", 32'h0100_0020, T_LOAD, P_U, 1'b0, 34'h0, 1'b1, 1'b1, 1);

      exp_ptw_q.push_back(34'h010_0014);
      exp_ptw_q.push_back(34'h000_9004);
      txn("s_load_user_nosum", 32'h0140_1008, T_LOAD, P_S, 1'b0, 34'h0, 1'b1, 1'b0, 0);
      exp_ptw_q.push_back(34'h010_0014);
      exp_ptw_q.push_back(34'h000_9004);
      txn("s_load_user_sum", 32'h0140_1008, T_LOAD, P_S, 1'b1, 34'h0_0006_6008, 1'b0, 1'b0, 0);
      txn("s_fetch_user_hit", 32'h0140_1008, T_FETCH, P_S, 1'b1, 34'h0, 1'b1, 1'b1, 1);
      txn("u_load_user_hit", 32'h0140_1010, T_LOAD, P_U, 1'b0, 34'h0_0006_6010, 1'b0, 1'b1, 1);
      txn("s_load_user_hit_nosum", 32'h0140_1010, T_LOAD, P_S, 1'b0, 34'h0, 1'b1, 1'b1, 1);
      txn("type11_as_load", 32'h0140_1010, 2'b11, P_U, 1'b0, 34'h0_0006_6010, 1'b0, 1'b1, 1);
      txn("u_store_readonly_hit", 32'h0140_1010, T_STORE, P_U, 1'b0, 34'h0, 1'b1, 1'b1, 1);

      pulse_sfence();
      exp_ptw_q.push_back(34'h010_0004);
      exp_ptw_q.push_back(34'h000_8004);
      txn("post_sfence_walk", 32'h0040_1004, T_LOAD, P_S, 1'b0, 34'h0_0048_D004, 1'b0, 1'b0, 0);

      pulse_sfence();
      for (int i = 0; i <= 16; i++) begin
         va = 32'h1000_0100 + (32'(i) << 22);
         l1 = 34'h010_0000 + (34'(32'h40 + i) << 2);
         pte_mem[l1] = (32'(i + 1) << 20) | 32'hCF;
         exp_ptw_q.push_back(l1);
         txn($sformatf("rr_fill_%0d", i), va, T_LOAD, P_S, 1'b0, (34'(i + 1) << 22) | 34'h100, 1'b0, 1'b0, 0);
      end
      txn("rr_survivor", 32'h1040_0100, T_LOAD, P_S, 1'b0, (34'd2 << 22) | 34'h100, 1'b0, 1'b1, 1);
      exp_ptw_q.push_back(34'h010_0100);
      txn("rr_evicted", 32'h1000_0100, T_LOAD, P_S, 1'b0, (34'd1 << 22) | 34'h100, 1'b0, 1'b0, 0);

      pte_mem[34'h010_0180] = (32'h30 << 20) | 32'hCF;
      resp_delay = 4;
      exp_ptw_q.push_back(34'h010_0180);
      expect_resp("sfence_mid_walk", 34'h0_0C00_0044, 1'b0, 1'b0, 0);
      send(32'h1800_0044, T_LOAD, P_S, 1'b0);
      @(posedge clk); #1;
      pulse_sfence();
      wait_done();
      resp_delay = 0;
      exp_ptw_q.push_back(34'h010_0180);
      txn("after_mid_walk_sfence", 32'h1800_0044, T_LOAD, P_S, 1'b0, 34'h0_0C00_0044, 1'b0, 1'b0, 0);
      txn("after_mid_walk_refill_hit", 32'h1800_0048, T_LOAD, P_S, 1'b0, 34'h0_0C00_0048, 1'b0, 1'b1, 1);

      pte_mem[34'h010_01C0] = (32'h31 << 20) | 32'hCF;
      ptw_req_ready = 1'b0;
      exp_ptw_q.push_back(34'h010_01C0);
      expect_resp("ptw_stall", 34'h0_0C40_0000, 1'b0, 1'b0, 0);
      send(32'h1C00_0000, T_LOAD, P_S, 1'b0);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("ptw_stall/valid", 64'(ptw_req_valid), 64'h1);
         chk("ptw_stall/addr", 64'(ptw_req_addr), 64'h10_01C0);
         chk("ptw_stall/req_ready", 64'(req_ready), 64'h0);
      end
      @(posedge clk); #1;
      ptw_req_ready = 1'b1;
      wait_done();

      repeat (3) @(posedge clk);
      #1;
      cur_name = "drain";
      chk("drain/resp_queue", 64'(exp_q.size()), 64'h0);
      chk("drain/ptw_queue", 64'(exp_ptw_q.size()), 64'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got simulation still running expected finish");
      $fatal(1, "watchdog expired");
   end

endmodule
